// File: rtl/snn_pkg.sv
// Shared constants and packet helpers for the spike routing logic.
// Packet layout: [2*ADDR_W-1:ADDR_W] origin, [ADDR_W-1:0] destination.
package snn_pkg;

    localparam int ADDR_W          = 12;
    localparam int PKT_W           = 2 * ADDR_W;
    localparam int PKT_ORIGIN_HI   = PKT_W - 1;
    localparam int PKT_ORIGIN_LO   = ADDR_W;
    localparam int PKT_DEST_HI     = ADDR_W - 1;
    localparam int PKT_DEST_LO     = 0;
    localparam int TS_CYCLES_DEF   = 4;
    localparam int NUM_NEURONS_DEF = 10;
    localparam int FIFO_DEPTH_DEF  = 8;

    function automatic logic [PKT_W-1:0] make_pkt(
        input logic [ADDR_W-1:0] origin,
        input logic [ADDR_W-1:0] dest
    );
        logic [PKT_W-1:0] p;
        p = '0;
        p[PKT_ORIGIN_HI:PKT_ORIGIN_LO] = origin;
        p[PKT_DEST_HI:PKT_DEST_LO]     = dest;
        return p;
    endfunction

endpackage

// File: rtl/spike_dispatch_scheduler_if.sv
// Spike packet valid/ready channel from network_interface.
// Ports: valid, data (origin|dest), ready; master drives, slave accepts.
interface spike_pkt_if #(
    parameter int W = snn_pkg::PKT_W
) ();

    logic         valid;
    logic [W-1:0] data;
    logic         ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/spike_fifo.sv
// Synchronous packet FIFO with combinational head and occupancy count.
// Ports: clk, reset, push, pop, wdata, rdata(head), full, empty, count.
module spike_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 24,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_dispatch_scheduler.sv
// Timestep sequencer and spike router: periodic clear, packet FIFO, one-hot dispatch.
// Ports: CLK, reset, enable, pkt (slave), clear, timestep, dispatch_*, fifo_count, overflow, drop_count.
module spike_dispatch_scheduler #(
    parameter  int NUM_NEURONS = snn_pkg::NUM_NEURONS_DEF,
    parameter  int TS_CYCLES   = snn_pkg::TS_CYCLES_DEF,
    parameter  int FIFO_DEPTH  = snn_pkg::FIFO_DEPTH_DEF,
    parameter  int ADDR_W      = snn_pkg::ADDR_W,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   enable,
    spike_pkt_if.slave             pkt,
    output logic                   clear,
    output logic [15:0]            timestep,
    output logic [NUM_NEURONS-1:0] dispatch_strobe,
    output logic [ADDR_W-1:0]      dispatch_source,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

    import snn_pkg::*;

    localparam int             PKT_LEN = 2 * ADDR_W;
    localparam int             PH_W    = $clog2(TS_CYCLES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(TS_CYCLES - 1);

    logic [PH_W-1:0]        phase;
    logic [PH_W-1:0]        phase_next;
    logic                   last_phase;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [PKT_LEN-1:0]     head;
    logic [ADDR_W-1:0]      head_origin;
    logic [ADDR_W-1:0]      head_dest;
    logic                   dest_ok;
    logic [NUM_NEURONS-1:0] strobe_next;

    assign last_phase  = (phase == PH_LAST);
    assign pkt.ready   = !fifo_full;
    assign push        = pkt.valid && !fifo_full;
    // Holding pop off in the last phase keeps strobes out of the clear cycle.
    assign pop         = enable && !fifo_empty && !last_phase;
    assign head_origin = head[PKT_LEN-1:ADDR_W];
    assign head_dest   = head[ADDR_W-1:0];

    spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_LEN)
    ) u_fifo (
        .clk   (CLK),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pkt.data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        phase_next = phase;
        if (enable) begin
            phase_next = last_phase ? '0 : phase + 1'b1;
        end
    end

    // Out-of-range destinations decode to no strobe and are counted as drops.
    always_comb begin
        strobe_next = '0;
        dest_ok     = 1'b0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (head_dest == ADDR_W'(i)) begin
                strobe_next[i] = 1'b1;
                dest_ok        = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            phase           <= '0;
            clear           <= 1'b0;
            timestep        <= '0;
            dispatch_strobe <= '0;
            dispatch_source <= '0;
            overflow        <= 1'b0;
            drop_count      <= '0;
        end else begin
            phase           <= phase_next;
            clear           <= enable && last_phase;
            dispatch_strobe <= '0;
            if (clear) begin
                timestep <= timestep + 16'd1;
            end
            if (pkt.valid && fifo_full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                if (dest_ok) begin
                    dispatch_strobe <= strobe_next;
                    dispatch_source <= head_origin;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_dispatch_scheduler.sv
// Self-checking bench for spike_dispatch_scheduler.
// Scoreboard queue of expected strobes; per-scenario tasks with inline checks.
`timescale 1ns/1ps
module tb_spike_dispatch_scheduler;

    import snn_pkg::*;

    localparam int NN = 10;
    localparam int TS = 4;
    localparam int FD = 8;
    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          reset;
    logic          enable;
    logic          clear;
    logic [15:0]   timestep;
    logic [NN-1:0] dispatch_strobe;
    logic [AW-1:0] dispatch_source;
    logic [3:0]    fifo_count;
    logic          overflow;
    logic [7:0]    drop_count;

    spike_pkt_if #(.W(2 * AW)) pkt ();

    spike_dispatch_scheduler #(
        .NUM_NEURONS (NN),
        .TS_CYCLES   (TS),
        .FIFO_DEPTH  (FD),
        .ADDR_W      (AW)
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .enable          (enable),
        .pkt             (pkt),
        .clear           (clear),
        .timestep        (timestep),
        .dispatch_strobe (dispatch_strobe),
        .dispatch_source (dispatch_source),
        .fifo_count      (fifo_count),
        .overflow        (overflow),
        .drop_count      (drop_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NN-1:0] strobe;
        logic [AW-1:0] src;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    int   tb_phase = 0;
    bit   tb_clear = 1'b0;
    int   tb_ts = 0;

    function automatic exp_t mk_exp(input int dest, input int origin);
        exp_t e;
        e.strobe = '0;
        e.strobe[dest] = 1'b1;
        e.src = AW'(origin);
        return e;
    endfunction

    function automatic logic [2*AW-1:0] pk(input int origin, input int dest);
        return make_pkt(AW'(origin), AW'(dest));
    endfunction

    // Advance one edge and keep a spec-level phase/timestep model.
    task automatic tick();
        @(posedge CLK);
        if (reset) begin
            tb_phase = 0;
            tb_clear = 1'b0;
            tb_ts = 0;
        end else begin
            if (tb_clear) tb_ts = (tb_ts + 1) % 65536;
            tb_clear = enable && (tb_phase == TS - 1);
            if (enable) tb_phase = (tb_phase + 1) % TS;
        end
        #1;
    endtask

    task automatic align(input int target);
        int n = 0;
        while (tb_phase != target && n < 2 * TS) begin
            tick();
            n++;
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((fifo_count != 0 || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++;
        if (fifo_count !== 4'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout count=%0d pending=%0d want 0/0", fifo_count, exp_q.size());
        end
    endtask

    // Every strobe must match the scoreboard head and never coincide with clear.
    always @(negedge CLK) begin
        if (mon_en && dispatch_strobe != '0) begin
            checks++;
            if (clear) begin
                errors++;
                $display("FAIL strobe_with_clear strobe=%b", dispatch_strobe);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got %b src=%0d want none", dispatch_strobe, dispatch_source);
            end else begin
                mon_e = exp_q.pop_front();
                if (dispatch_strobe !== mon_e.strobe || dispatch_source !== mon_e.src) begin
                    errors++;
                    $display("FAIL scoreboard got %b/%0d want %b/%0d", dispatch_strobe, dispatch_source, mon_e.strobe, mon_e.src);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        pkt.valid = 1'b0;
        pkt.data = '0;
        repeat (3) tick();
        mon_en = 1'b1;
        checks++; if (clear !== 1'b0) begin errors++; $display("FAIL rst_clear got %b want 0", clear); end
        checks++; if (timestep !== 16'd0) begin errors++; $display("FAIL rst_ts got %0d want 0", timestep); end
        checks++; if (dispatch_strobe !== '0) begin errors++; $display("FAIL rst_strobe got %b want 0", dispatch_strobe); end
        checks++; if (dispatch_source !== '0) begin errors++; $display("FAIL rst_src got %0d want 0", dispatch_source); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_drop got %0d want 0", drop_count); end
        checks++; if (pkt.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", pkt.ready); end
    endtask

    task automatic test_timesteps();
        logic exp_clr;
        reset = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_clr = (k % 4 == 0);
            checks++;
            if (clear !== exp_clr) begin
                errors++;
                $display("FAIL idle_clear k=%0d got %b want %b", k, clear, exp_clr);
            end
            checks++;
            if (timestep !== 16'((k - 1) / 4)) begin
                errors++;
                $display("FAIL idle_ts k=%0d got %0d want %0d", k, timestep, (k - 1) / 4);
            end
        end
    endtask

    task automatic test_single();
        align(0);
        pkt.valid = 1'b1;
        pkt.data = pk(3, 6);
        exp_q.push_back(mk_exp(6, 3));
        tick();
        pkt.valid = 1'b0;
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", fifo_count); end
        checks++; if (dispatch_strobe !== '0) begin errors++; $display("FAIL single_early got %b want 0", dispatch_strobe); end
        tick();
        checks++; if (dispatch_strobe !== 10'b0001000000) begin errors++; $display("FAIL single_strobe got %b want 0001000000", dispatch_strobe); end
        checks++; if (dispatch_source !== 12'd3) begin errors++; $display("FAIL single_src got %0d want 3", dispatch_source); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", fifo_count); end
        tick();
        checks++; if (dispatch_strobe !== '0) begin errors++; $display("FAIL single_oneshot got %b want 0", dispatch_strobe); end
        checks++; if (dispatch_source !== 12'd3) begin errors++; $display("FAIL single_hold got %0d want 3", dispatch_source); end
    endtask

    task automatic test_back_to_back();
        int ts0;
        align(1);
        ts0 = tb_ts;
        pkt.valid = 1'b1;
        pkt.data = pk(21, 0);
        exp_q.push_back(mk_exp(0, 21));
        tick();
        pkt.data = pk(22, 5);
        exp_q.push_back(mk_exp(5, 22));
        tick();
        checks++; if (dispatch_strobe !== 10'b0000000001) begin errors++; $display("FAIL b2b_first got %b want 0000000001", dispatch_strobe); end
        pkt.data = pk(23, 9);
        exp_q.push_back(mk_exp(9, 23));
        tick();
        pkt.valid = 1'b0;
        checks++; if (clear !== 1'b1) begin errors++; $display("FAIL b2b_clear got %b want 1", clear); end
        checks++; if (dispatch_strobe !== '0) begin errors++; $display("FAIL b2b_gap got %b want 0", dispatch_strobe); end
        tick();
        checks++; if (dispatch_strobe !== 10'b0000100000) begin errors++; $display("FAIL b2b_second got %b want 0000100000", dispatch_strobe); end
        tick();
        checks++; if (dispatch_strobe !== 10'b1000000000) begin errors++; $display("FAIL b2b_third got %b want 1000000000", dispatch_strobe); end
        checks++; if (dispatch_source !== 12'd23) begin errors++; $display("FAIL b2b_src got %0d want 23", dispatch_source); end
        checks++; if (timestep !== 16'(ts0 + 1)) begin errors++; $display("FAIL b2b_ts got %0d want %0d", timestep, ts0 + 1); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL b2b_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_overflow();
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pkt.valid = 1'b1;
            pkt.data = pk(100 + i, i);
            if (i < 8) exp_q.push_back(mk_exp(i, 100 + i));
            tick();
            if (i == 7) begin
                checks++; if (pkt.ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b want 0", pkt.ready); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
            end
        end
        pkt.valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", fifo_count); end
        enable = 1'b1;
        drain(60);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        checks++; if (pkt.ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_back got %b want 1", pkt.ready); end
    endtask

    task automatic test_drop();
        int n;
        int acc;
        logic rdy;
        enable = 1'b1;
        pkt.valid = 1'b1;
        pkt.data = pk(5, 12);
        tick();
        pkt.valid = 1'b0;
        drain(20);
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_one got %0d want 1", drop_count); end
        n = 0;
        acc = 0;
        while (acc < 254 && n < 2000) begin
            rdy = pkt.ready;
            pkt.valid = rdy;
            pkt.data = pk(7, NN);
            tick();
            if (rdy) acc++;
            n++;
        end
        pkt.valid = 1'b0;
        drain(40);
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_255 got %0d want 255", drop_count); end
        pkt.valid = 1'b1;
        pkt.data = pk(8, 4095);
        tick();
        pkt.valid = 1'b0;
        drain(20);
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", drop_count); end
        pkt.valid = 1'b1;
        pkt.data = pk(9, 2);
        exp_q.push_back(mk_exp(2, 9));
        tick();
        pkt.valid = 1'b0;
        drain(20);
    endtask

    task automatic test_reset_mid();
        logic exp_clr;
        enable = 1'b1;
        align(2);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pkt.valid = 1'b1;
            pkt.data = pk(50 + i, i);
            tick();
        end
        checks++; if (fifo_count !== 4'd4) begin errors++; $display("FAIL mid_queued got %0d want 4", fifo_count); end
        reset = 1'b1;
        enable = 1'b1;
        pkt.data = pk(60, 1);
        tick();
        reset = 1'b0;
        pkt.valid = 1'b0;
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fifo_count); end
        checks++; if (timestep !== 16'd0) begin errors++; $display("FAIL mid_ts got %0d want 0", timestep); end
        checks++; if (clear !== 1'b0) begin errors++; $display("FAIL mid_clear got %b want 0", clear); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", overflow); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_drop got %0d want 0", drop_count); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_clr = (k % 4 == 0);
            checks++;
            if (clear !== exp_clr) begin
                errors++;
                $display("FAIL mid_phase k=%0d got %b want %b", k, clear, exp_clr);
            end
        end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_after got %0d want 0", fifo_count); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_timesteps();
        test_single();
        test_back_to_back();
        test_overflow();
        test_drop();
        test_reset_mid();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
